// File: rtl/ss_pkg.sv
// Shared types and sizing for the serial extreme-value search engine.
// The optional SS_MIN_SEARCH_EN macro (see ss_datapath) does not affect this package.
package ss_pkg;

   localparam int DATA_W = 6;
   localparam int N      = 8;
   localparam int IDX_W  = $clog2(N);

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      LOAD,
      DONE
   } state_t;

   localparam idx_t LAST_IDX = idx_t'(N - 1);

endpackage

// File: rtl/ss_datapath.sv
// Word counter, best-value/best-index registers and comparator for serial_max_index.
// Define SS_MIN_SEARCH_EN to search for the earliest minimum instead of the earliest maximum.
module ss_datapath
   import ss_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              last,
   output logic [IDX_W-1:0]  win_idx
);

   idx_t  count;
   data_t best;
   idx_t  best_idx;
   logic  better;
   logic  take;

   // Strict comparison keeps the earliest index when values tie.
   always_comb begin
      better = 1'b0;
`ifdef SS_MIN_SEARCH_EN
      better = (data < best);
`else
      better = (data > best);
`endif
      take = (count == '0) || better;
   end

   assign last    = (count == LAST_IDX);
   assign win_idx = take ? count : best_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         best     <= '0;
         best_idx <= '0;
      end else if (clear) begin
         count    <= '0;
         best     <= '0;
         best_idx <= '0;
      end else if (load) begin
         if (take) begin
            best     <= data;
            best_idx <= count;
         end
         count <= last ? '0 : count + idx_t'(1);
      end
   end

endmodule

// File: rtl/serial_max_index.sv
// Controller for the serial extreme-value search: IDLE -> INIT -> LOAD -> DONE.
// Search direction is chosen in ss_datapath by SS_MIN_SEARCH_EN (default: maximum).
module serial_max_index
   import ss_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inBus,
   input  logic              Start,
   output logic              Ready,
   output logic [IDX_W-1:0]  outBus
);

   state_t state;
   logic   clear;
   logic   load;
   logic   last;
   idx_t   win_idx;

   assign clear = (state == INIT);
   assign load  = (state == LOAD);

   ss_datapath u_datapath (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .load    (load),
      .data    (inBus),
      .last    (last),
      .win_idx (win_idx)
   );

   // outBus captures the winner of the final sample, so it survives the clear in INIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         Ready  <= 1'b0;
         outBus <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) state <= INIT;
            end
            INIT: begin
               Ready <= 1'b0;
               if (!Start) state <= LOAD;
            end
            LOAD: begin
               if (last) begin
                  state  <= DONE;
                  Ready  <= 1'b1;
                  outBus <= win_idx;
               end
            end
            DONE: begin
               if (Start) begin
                  state <= INIT;
                  Ready <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_max_index.sv
// Table-driven self-checking bench for serial_max_index, with hand-written reset/restart sequences.
// Expected indices are hand-computed for both maximum and SS_MIN_SEARCH_EN builds.
module tb_serial_max_index;

   logic       clk;
   logic       rst;
   logic [5:0] inBus;
   logic       Start;
   logic       Ready;
   logic [2:0] outBus;

   int checks;
   int failures;

   typedef struct {
      string      name;
      logic [5:0] words [8];
      int         exp_max;
      int         exp_min;
   } vec_t;

   vec_t tbl [7];

   serial_max_index dut (
      .clk    (clk),
      .rst    (rst),
      .inBus  (inBus),
      .Start  (Start),
      .Ready  (Ready),
      .outBus (outBus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int pickExpected(input vec_t v);
`ifdef SS_MIN_SEARCH_EN
      return v.exp_min;
`else
      return v.exp_max;
`endif
   endfunction

   // Start for one cycle, one idle cycle, then eight words; optional Start pulse during word 3.
   task automatic applyStimulus(input vec_t v, input logic pulse_mid);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      checkOutput({v.name, "_ready_drop"}, int'(Ready), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         inBus = v.words[i];
         Start = pulse_mid && (i == 3);
         @(posedge clk);
         #1 Start = 1'b0;
         if (i == 6) checkOutput({v.name, "_ready_early"}, int'(Ready), 0);
      end
      checkOutput({v.name, "_ready"}, int'(Ready), 1);
      checkOutput({v.name, "_index"}, int'(outBus), pickExpected(v));
   endtask

   initial begin
      int held;
      checks   = 0;
      failures = 0;

      tbl[0].name = "basic";  tbl[0].words = '{5, 17, 3, 42, 9, 0, 41, 12};  tbl[0].exp_max = 3; tbl[0].exp_min = 5;
      tbl[1].name = "tie";    tbl[1].words = '{7, 30, 30, 2, 30, 1, 0, 4};   tbl[1].exp_max = 1; tbl[1].exp_min = 6;
      tbl[2].name = "zeros";  tbl[2].words = '{0, 0, 0, 0, 0, 0, 0, 0};      tbl[2].exp_max = 0; tbl[2].exp_min = 0;
      tbl[3].name = "last63"; tbl[3].words = '{0, 0, 0, 0, 0, 0, 0, 63};     tbl[3].exp_max = 7; tbl[3].exp_min = 0;
      tbl[4].name = "all63";  tbl[4].words = '{63, 63, 63, 63, 63, 63, 63, 63}; tbl[4].exp_max = 0; tbl[4].exp_min = 0;
      tbl[5].name = "minvec"; tbl[5].words = '{20, 8, 33, 8, 50, 12, 9, 40}; tbl[5].exp_max = 4; tbl[5].exp_min = 1;
      tbl[6].name = "ascend"; tbl[6].words = '{1, 2, 3, 4, 5, 6, 7, 8};      tbl[6].exp_max = 7; tbl[6].exp_min = 0;

      rst   = 1'b0;
      Start = 1'b0;
      inBus = '0;
      #1;
      checkOutput("reset_ready", int'(Ready), 0);
      checkOutput("reset_index", int'(outBus), 0);
      #20 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) applyStimulus(tbl[i], 1'b0);

      // Result must hold in DONE without Start.
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_ready", int'(Ready), 1);
         checkOutput("hold_index", int'(outBus), pickExpected(tbl[6]));
      end

      // Start during LOAD must not disturb the search.
      tbl[6].name = "midstart";
      applyStimulus(tbl[6], 1'b1);

      // Asynchronous reset in the middle of LOAD.
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         inBus = tbl[0].words[i];
         @(posedge clk);
         #1;
      end
      #2 rst = 1'b0;
      #1;
      checkOutput("async_reset_ready", int'(Ready), 0);
      checkOutput("async_reset_index", int'(outBus), 0);
      #2 rst = 1'b1;
      held = 0;
      for (int c = 0; c < 12; c++) begin
         inBus = 6'(c + 1);
         @(posedge clk);
         #1;
         if (Ready) held++;
      end
      checkOutput("idle_after_reset", held, 0);

      applyStimulus(tbl[0], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
